// File: rtl/radiation_pulse_processor.sv
// Pulse front end: tracks an IIR baseline and triggers on samples above baseline + threshold.
// Each pulse yields either a baseline-subtracted peak height or a pile-up count.
module radiation_pulse_processor #(
    parameter int unsigned ADC_WIDTH      = 12,
    parameter int unsigned VALUE_WIDTH    = 10,
    parameter int unsigned BASELINE_SHIFT = 4,
    parameter int unsigned MAX_WIDTH      = 64,
    parameter int unsigned READY_HOLD     = 4,
    parameter int unsigned HOLDOFF        = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sampleValid,
    input  logic [ADC_WIDTH-1:0]   sampleData,
    input  logic                   enable,
    input  logic [ADC_WIDTH-1:0]   threshold,
    output logic                   valueReady,
    output logic [VALUE_WIDTH-1:0] radiationValue,
    output logic [ADC_WIDTH-1:0]   baseline,
    output logic [15:0]            eventCount,
    output logic [15:0]            pileupCount,
    output logic                   busy
);

    localparam int unsigned ACC_W      = ADC_WIDTH + BASELINE_SHIFT;
    localparam int unsigned SHIFT_DOWN = ADC_WIDTH - VALUE_WIDTH;
    localparam int unsigned WIDTH_W    = $clog2(MAX_WIDTH + 1);
    localparam int unsigned CNT_W      = $clog2(READY_HOLD + HOLDOFF + 1) + 1;
    localparam int unsigned VALUE_MAX  = (2 ** VALUE_WIDTH) - 1;
    localparam int unsigned READY_LAST = (READY_HOLD > 0) ? READY_HOLD - 1 : 0;
    localparam int unsigned HOLD_LAST  = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_REPORT, S_HOLDOFF} state_t;

    state_t                  state;
    state_t                  stateNext;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        accNext;
    logic [ADC_WIDTH-1:0]    peak;
    logic [WIDTH_W-1:0]      width;
    logic [CNT_W-1:0]        phaseCnt;
    logic [ADC_WIDTH:0]      triggerLevel;
    logic                    aboveLevel;
    logic [ADC_WIDTH-1:0]    heightShift;
    logic [VALUE_WIDTH-1:0]  heightSat;
    logic                    accEn;
    logic                    startPulse;
    logic                    peakEn;
    logic                    widthEn;
    logic                    pileupHit;
    logic                    reportHit;

    assign baseline = acc[ACC_W-1:BASELINE_SHIFT];

    // Trigger compare at one extra bit so baseline + threshold cannot wrap
    always_comb begin
        triggerLevel = {1'b0, baseline} + {1'b0, threshold};
        aboveLevel   = {1'b0, sampleData} > triggerLevel;
        accNext      = acc + ACC_W'(sampleData) - ACC_W'(baseline);
        heightShift  = (peak - baseline) >> SHIFT_DOWN;
        if (heightShift > ADC_WIDTH'(VALUE_MAX)) begin
            heightSat = VALUE_WIDTH'(VALUE_MAX);
        end else begin
            heightSat = VALUE_WIDTH'(heightShift);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        accEn      = 1'b0;
        startPulse = 1'b0;
        peakEn     = 1'b0;
        widthEn    = 1'b0;
        pileupHit  = 1'b0;
        reportHit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (sampleValid) begin
                    if (enable && aboveLevel) begin
                        startPulse = 1'b1;
                        stateNext  = S_TRACK;
                    end else begin
                        accEn = 1'b1;
                    end
                end
            end
            S_TRACK: begin
                if (sampleValid) begin
                    if (!aboveLevel) begin
                        reportHit = 1'b1;
                        stateNext = S_REPORT;
                    end else begin
                        peakEn  = sampleData > peak;
                        widthEn = 1'b1;
                        if (width == WIDTH_W'(MAX_WIDTH - 1)) begin
                            pileupHit = 1'b1;
                            stateNext = S_HOLDOFF;
                        end
                    end
                end
            end
            S_REPORT: begin
                if (phaseCnt == CNT_W'(READY_LAST)) begin
                    stateNext = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (phaseCnt == CNT_W'(HOLD_LAST)) begin
                    stateNext = S_IDLE;
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc            <= '0;
            peak           <= '0;
            width          <= '0;
            phaseCnt       <= '0;
            valueReady     <= 1'b0;
            radiationValue <= '0;
            eventCount     <= '0;
            pileupCount    <= '0;
            busy           <= 1'b0;
        end else begin
            busy       <= stateNext != S_IDLE;
            valueReady <= stateNext == S_REPORT;
            if ((stateNext == state) && ((state == S_REPORT) || (state == S_HOLDOFF))) begin
                phaseCnt <= phaseCnt + CNT_W'(1);
            end else begin
                phaseCnt <= '0;
            end
            if (accEn) begin
                acc <= accNext;
            end
            if (startPulse || peakEn) begin
                peak <= sampleData;
            end
            if (startPulse) begin
                width <= WIDTH_W'(1);
            end else if (widthEn) begin
                width <= width + WIDTH_W'(1);
            end
            if (reportHit) begin
                radiationValue <= heightSat;
                eventCount     <= eventCount + 16'd1;
            end
            if (pileupHit) begin
                pileupCount <= pileupCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_radiation_pulse_processor.sv
// Bench for radiation_pulse_processor: directed table, corner sequences and random
// stimulus, all compared against an event-level reference model.
module tb_radiation_pulse_processor;

    localparam int SHIFT   = 4;
    localparam int DSHIFT  = 2;
    localparam int VMAX    = 1023;
    localparam int MAXW    = 64;
    localparam int RHOLD   = 4;
    localparam int HOLDOFF = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sampleValid = 1'b0;
    logic [11:0] sampleData = '0;
    logic        enable = 1'b0;
    logic [11:0] threshold = '0;
    logic        valueReady;
    logic [9:0]  radiationValue;
    logic [11:0] baseline;
    logic [15:0] eventCount;
    logic [15:0] pileupCount;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model: pulse in progress flag plus remaining report/dead-time cycles
    int mAcc = 0, mPeak = 0, mWidth = 0, mValue = 0, mEvents = 0, mPile = 0;
    int readyLeft = 0, holdLeft = 0;
    bit inPulse = 0;

    typedef struct {
        logic [11:0] data;
        logic        valid;
        logic        expReady;
        int          expValue;
        int          expEvents;
        logic        expBusy;
    } vec_t;

    vec_t pulseTab[8];

    radiation_pulse_processor dut (
        .clk(clk), .reset(reset), .sampleValid(sampleValid), .sampleData(sampleData),
        .enable(enable), .threshold(threshold), .valueReady(valueReady),
        .radiationValue(radiationValue), .baseline(baseline), .eventCount(eventCount),
        .pileupCount(pileupCount), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelEdge();
        int base;
        bit above;
        base  = mAcc >> SHIFT;
        above = int'(sampleData) > base + int'(threshold);
        if (!reset) begin
            mAcc = 0; mPeak = 0; mWidth = 0; mValue = 0; mEvents = 0; mPile = 0;
            readyLeft = 0; holdLeft = 0; inPulse = 0;
        end else if (readyLeft > 0) begin
            readyLeft--;
            if (readyLeft == 0) holdLeft = HOLDOFF;
        end else if (holdLeft > 0) begin
            holdLeft--;
        end else if (inPulse) begin
            if (sampleValid) begin
                if (!above) begin
                    inPulse   = 0;
                    mValue    = (mPeak - base) >> DSHIFT;
                    if (mValue > VMAX) mValue = VMAX;
                    mEvents   = (mEvents + 1) % 65536;
                    readyLeft = RHOLD;
                end else begin
                    if (int'(sampleData) > mPeak) mPeak = int'(sampleData);
                    mWidth++;
                    if (mWidth == MAXW) begin
                        mPile    = (mPile + 1) % 65536;
                        inPulse  = 0;
                        holdLeft = HOLDOFF;
                    end
                end
            end
        end else if (sampleValid) begin
            if (enable && above) begin
                inPulse = 1;
                mPeak   = int'(sampleData);
                mWidth  = 1;
            end else begin
                mAcc = (mAcc + int'(sampleData) - base) % 65536;
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [11:0] d,
                        input logic e, input logic [11:0] t);
        reset = r; sampleValid = v; sampleData = d; enable = e; threshold = t;
        @(posedge clk);
        modelEdge();
        #1;
        chk("valueReady", int'(valueReady), int'(readyLeft > 0));
        chk("radiationValue", int'(radiationValue), mValue);
        chk("baseline", int'(baseline), mAcc >> SHIFT);
        chk("eventCount", int'(eventCount), mEvents);
        chk("pileupCount", int'(pileupCount), mPile);
        chk("busy", int'(busy), int'(inPulse || readyLeft > 0 || holdLeft > 0));
    endtask

    initial begin
        logic [11:0] amp;
        int burstLeft;

        pulseTab[0] = '{12'd700,  1'b1, 1'b0, 0,   0, 1'b1};
        pulseTab[1] = '{12'd1200, 1'b1, 1'b0, 0,   0, 1'b1};
        pulseTab[2] = '{12'd900,  1'b1, 1'b0, 0,   0, 1'b1};
        pulseTab[3] = '{12'd420,  1'b1, 1'b1, 200, 1, 1'b1};
        pulseTab[4] = '{12'd0,    1'b0, 1'b1, 200, 1, 1'b1};
        pulseTab[5] = '{12'd0,    1'b0, 1'b1, 200, 1, 1'b1};
        pulseTab[6] = '{12'd0,    1'b0, 1'b1, 200, 1, 1'b1};
        pulseTab[7] = '{12'd0,    1'b0, 1'b0, 200, 1, 1'b1};

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'd0, 1'b0, 12'd0);
        chk("reset_valueReady", int'(valueReady), 0);
        chk("reset_eventCount", int'(eventCount), 0);
        chk("reset_busy", int'(busy), 0);

        // Baseline settling with an unreachable threshold
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 12'd400, 1'b1, 12'd4095);
        chk("settle_baseline", int'(baseline), 400);
        chk("settle_eventCount", int'(eventCount), 0);

        // Basic pulse from the table
        for (int i = 0; i < 8; i++) begin
            step(1'b1, pulseTab[i].valid, pulseTab[i].data, 1'b1, 12'd50);
            chk($sformatf("tab%0d_valueReady", i), int'(valueReady), int'(pulseTab[i].expReady));
            chk($sformatf("tab%0d_radiationValue", i), int'(radiationValue), pulseTab[i].expValue);
            chk($sformatf("tab%0d_eventCount", i), int'(eventCount), pulseTab[i].expEvents);
            chk($sformatf("tab%0d_busy", i), int'(busy), int'(pulseTab[i].expBusy));
            chk($sformatf("tab%0d_baseline", i), int'(baseline), 400);
        end

        // Second pulse during dead time is ignored
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 12'd800, 1'b1, 12'd50);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 12'd0, 1'b1, 12'd50);
        chk("holdoff_eventCount", int'(eventCount), 1);
        chk("holdoff_busy", int'(busy), 0);
        chk("holdoff_baseline", int'(baseline), 400);

        // Same pulse with enable low only moves the baseline
        step(1'b1, 1'b1, 12'd800, 1'b0, 12'd50);
        chk("disabled_baseline", int'(baseline), 425);
        chk("disabled_busy", int'(busy), 0);
        for (int i = 0; i < 200; i++) step(1'b1, 1'b1, 12'd400, 1'b0, 12'd50);
        chk("resettle_baseline", int'(baseline), 400);

        // Pile-up: 70 consecutive samples far above threshold
        for (int i = 0; i < 70; i++) step(1'b1, 1'b1, 12'd1000, 1'b1, 12'd50);
        step(1'b1, 1'b0, 12'd0, 1'b1, 12'd50);
        chk("pileup_busy_7", int'(busy), 1);
        step(1'b1, 1'b0, 12'd0, 1'b1, 12'd50);
        chk("pileup_busy_8", int'(busy), 0);
        chk("pileup_count", int'(pileupCount), 1);
        chk("pileup_eventCount", int'(eventCount), 1);

        // Full-scale pulse on a zero baseline saturates
        step(1'b0, 1'b0, 12'd0, 1'b1, 12'd10);
        step(1'b1, 1'b1, 12'd4095, 1'b1, 12'd10);
        step(1'b1, 1'b1, 12'd0, 1'b1, 12'd10);
        chk("fullscale_value", int'(radiationValue), 1023);
        chk("fullscale_ready", int'(valueReady), 1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 12'd0, 1'b1, 12'd10);

        // Reset while tracking aborts the event
        step(1'b1, 1'b1, 12'd500, 1'b1, 12'd10);
        chk("midreset_tracking", int'(busy), 1);
        step(1'b0, 1'b0, 12'd0, 1'b1, 12'd10);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_eventCount", int'(eventCount), 0);
        chk("midreset_value", int'(radiationValue), 0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 12'd0, 1'b1, 12'd10);
            chk("midreset_noReady", int'(valueReady), 0);
        end

        // Random traffic: noise around 400 with occasional bursts
        burstLeft = 0;
        amp = 12'd0;
        threshold = 12'd60;
        for (int i = 0; i < 5000; i++) begin
            logic [11:0] d;
            logic [11:0] thr;
            thr = threshold;
            if (($urandom % 200) == 0) thr = 12'($urandom_range(20, 300));
            if (burstLeft == 0 && ($urandom % 30) == 0) begin
                burstLeft = $urandom_range(1, 80);
                amp = 12'($urandom_range(600, 4095));
            end
            if (burstLeft > 0) begin
                d = amp - 12'($urandom_range(0, 100));
                burstLeft--;
            end else begin
                d = 12'($urandom_range(350, 450));
            end
            step(($urandom % 800) != 0, ($urandom % 4) != 0, d, ($urandom % 10) != 0, thr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
